// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - pixel-write FIFO draining into the framebuffer SRAM during blanking
//
// Purpose: accepts (address, colour) pixel writes from the rasterizer, buffers them in a
// DEPTH-entry FIFO and writes them to the framebuffer through the GPU-side SRAM port, one
// SETUP/STROBE/HOLD sequence per pixel, only while the display is blanked. Raises a pipeline
// stall when the FIFO is nearly full or a frame flush is pending, and pulses O_FLUSH_DONE
// when a requested flush has fully drained.
//
// Ports:
//   I_CLK, I_RST_N             clock, synchronous active-low reset
//   I_PIX_VALID/O_PIX_READY    pixel handshake; I_PIX_ADDR / I_PIX_DATA pixel payload
//   I_FRAME_END                one-cycle flush request
//   I_VIDEO_ON                 display owns the SRAM; no GPU write may start
//   O_GPU_ADDR/DATA/WRITE/READ registered SRAM write port (READ tied low)
//   O_FRAMESTALL               registered stall request to the pipeline
//   O_FLUSH_DONE               one-cycle flush-complete pulse
//   O_LEVEL                    FIFO occupancy
//   O_DROP_CNT                 saturating count of out-of-range pixels

module fb_pixel_writer #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int FB_WORDS = 76800
) (
    input  logic                       I_CLK,
    input  logic                       I_RST_N,
    input  logic                       I_PIX_VALID,
    output logic                       O_PIX_READY,
    input  logic [ADDR_W-1:0]          I_PIX_ADDR,
    input  logic [DATA_W-1:0]          I_PIX_DATA,
    input  logic                       I_FRAME_END,
    input  logic                       I_VIDEO_ON,
    output logic [ADDR_W-1:0]          O_GPU_ADDR,
    output logic [DATA_W-1:0]          O_GPU_DATA,
    output logic                       O_GPU_WRITE,
    output logic                       O_GPU_READ,
    output logic                       O_FRAMESTALL,
    output logic                       O_FLUSH_DONE,
    output logic [$clog2(DEPTH):0]     O_LEVEL,
    output logic [15:0]                O_DROP_CNT
);

    localparam int                PW        = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] FB_LIMIT  = ADDR_W'(FB_WORDS);
    localparam logic [PW:0]       STALL_LVL = (PW+1)'(DEPTH - 2);
    localparam logic [PW:0]       FULL_LVL  = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    mem_addr_q [DEPTH];
    logic [DATA_W-1:0]    mem_data_q [DEPTH];
    logic [PW:0]          wr_ptr_q, wr_ptr_d;
    logic [PW:0]          rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]    gpu_addr_q, gpu_addr_d;
    logic [DATA_W-1:0]    gpu_data_q, gpu_data_d;
    logic                 gpu_write_q, gpu_write_d;
    logic                 stall_q, stall_d;
    logic                 flush_pend_q, flush_pend_d;
    logic                 flush_done_q, flush_done_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic [PW:0]          level;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pix_ready;
    logic                 push;
    logic                 in_range;
    logic                 store;
    logic                 drop;
    logic                 pop;

    // Extra pointer MSB: equal pointers mean empty, difference of DEPTH means full.
    assign level      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LVL);
    // Held low while reset is asserted so nothing is accepted until release.
    assign pix_ready  = !fifo_full && I_RST_N;
    assign push       = I_PIX_VALID && pix_ready;
    assign in_range   = (I_PIX_ADDR < FB_LIMIT);
    assign store      = push && in_range;
    assign drop       = push && !in_range;
    // The head is only consumed once its strobe has completed; an aborted SETUP leaves it.
    assign pop        = (state_q == S_HOLD);

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q + (PW+1)'(store);
        rd_ptr_d     = rd_ptr_q + (PW+1)'(pop);
        gpu_addr_d   = gpu_addr_q;
        gpu_data_d   = gpu_data_q;
        gpu_write_d  = 1'b0;
        flush_pend_d = flush_pend_q;
        flush_done_d = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        stall_d      = flush_pend_q || (level >= STALL_LVL);

        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !I_VIDEO_ON) begin
                    state_d    = S_SETUP;
                    gpu_addr_d = mem_addr_q[rd_ptr_q[PW-1:0]];
                    gpu_data_d = mem_data_q[rd_ptr_q[PW-1:0]];
                end
            end
            S_SETUP: begin
                if (I_VIDEO_ON) begin
                    state_d = S_IDLE;
                end else begin
                    state_d     = S_STROBE;
                    gpu_write_d = 1'b1;
                end
            end
            S_STROBE: state_d = S_HOLD;
            S_HOLD:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // A request arriving while a flush is pending folds into that flush.
        if (flush_pend_q && fifo_empty && (state_q == S_IDLE)) begin
            flush_pend_d = 1'b0;
            flush_done_d = 1'b1;
        end else if (I_FRAME_END && !flush_pend_q) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            gpu_addr_q   <= '0;
            gpu_data_q   <= '0;
            gpu_write_q  <= 1'b0;
            stall_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            gpu_addr_q   <= gpu_addr_d;
            gpu_data_q   <= gpu_data_d;
            gpu_write_q  <= gpu_write_d;
            stall_q      <= stall_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge I_CLK) begin
        if (store) begin
            mem_addr_q[wr_ptr_q[PW-1:0]] <= I_PIX_ADDR;
            mem_data_q[wr_ptr_q[PW-1:0]] <= I_PIX_DATA;
        end
    end

    assign O_PIX_READY  = pix_ready;
    assign O_GPU_ADDR   = gpu_addr_q;
    assign O_GPU_DATA   = gpu_data_q;
    assign O_GPU_WRITE  = gpu_write_q;
    assign O_GPU_READ   = 1'b0;
    assign O_FRAMESTALL = stall_q;
    assign O_FLUSH_DONE = flush_done_q;
    assign O_LEVEL      = level;
    assign O_DROP_CNT   = drop_cnt_q;

endmodule
